// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX_T        = 5;
  localparam int unsigned MIN_MAX_T        = 5;
  localparam int unsigned DIGIT_MAX        = 9;
  localparam int unsigned HOUR_MAX_DEFAULT = 23;
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_TENS:MAX_UNITS; wrap is the
// combinational carry-out for the next stage.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX_TENS  = SEC_MAX_T,
  parameter int unsigned MAX_UNITS = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap
);

  logic at_max;

  assign at_max = (tens == 4'(MAX_TENS)) && (units == 4'(MAX_UNITS));
  assign wrap   = inc && at_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'(DIGIT_MAX)) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter: prescaler, set-input edge detection and a
// seconds -> minutes -> hours carry chain.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned HOUR_MAX = HOUR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       clr_sec,
  output logic [3:0] hr_MSB,
  output logic [3:0] hr_LSB,
  output logic [3:0] min_MSB,
  output logic [3:0] min_LSB,
  output logic [3:0] secs_MSB,
  output logic [3:0] secs_LSB,
  output logic       sec_tick,
  output logic       day_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] presc;
  logic          inc_min_q, inc_hr_q, clr_sec_q;
  logic          min_edge, hr_edge, clr_edge;
  logic          tick, sec_inc, min_inc, hr_inc;
  logic          sec_wrap, min_wrap, hr_wrap;

  assign min_edge = inc_min && !inc_min_q;
  assign hr_edge  = inc_hr  && !inc_hr_q;
  assign clr_edge = clr_sec && !clr_sec_q;

  assign tick    = run && (presc == CW'(TICK_DIV - 1));
  // A clear wins over a coincident tick: no count, no carry, no sec_tick.
  assign sec_inc = tick && !clr_edge;
  // Manual edges are consumed while running but only act in set mode. Minute
  // wraps from manual setting never carry, so only a seconds carry reaches hours.
  assign min_inc = sec_wrap || (min_edge && !run);
  assign hr_inc  = (sec_wrap && min_wrap) || (hr_edge && !run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      inc_min_q <= 1'b0;
      inc_hr_q  <= 1'b0;
      clr_sec_q <= 1'b0;
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
    end else begin
      inc_min_q <= inc_min;
      inc_hr_q  <= inc_hr;
      clr_sec_q <= clr_sec;
      sec_tick  <= sec_inc;
      day_tick  <= sec_wrap && min_wrap && hr_wrap;
      if (clr_edge || tick) presc <= '0;
      else if (run)         presc <= presc + 1'b1;
    end
  end

  bcd_pair_counter #(.MAX_TENS(SEC_MAX_T), .MAX_UNITS(DIGIT_MAX)) u_secs (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (clr_edge),
    .tens  (secs_MSB),
    .units (secs_LSB),
    .wrap  (sec_wrap)
  );

  bcd_pair_counter #(.MAX_TENS(MIN_MAX_T), .MAX_UNITS(DIGIT_MAX)) u_mins (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (min_MSB),
    .units (min_LSB),
    .wrap  (min_wrap)
  );

  bcd_pair_counter #(.MAX_TENS(HOUR_MAX / 10), .MAX_UNITS(HOUR_MAX % 10)) u_hours (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .tens  (hr_MSB),
    .units (hr_LSB),
    .wrap  (hr_wrap)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with TICK_DIV=4; digits compared as a
// packed 24-bit HHMMSS BCD word against hand-computed values.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n, run, inc_min, inc_hr, clr_sec;
  logic [3:0] hr_MSB, hr_LSB, min_MSB, min_LSB, secs_MSB, secs_LSB;
  logic       sec_tick, day_tick;

  int errors = 0;
  int checks = 0;

  bcd_time_counter #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .clr_sec  (clr_sec),
    .hr_MSB   (hr_MSB),
    .hr_LSB   (hr_LSB),
    .min_MSB  (min_MSB),
    .min_LSB  (min_LSB),
    .secs_MSB (secs_MSB),
    .secs_LSB (secs_LSB),
    .sec_tick (sec_tick),
    .day_tick (day_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] disp();
    return {hr_MSB, hr_LSB, min_MSB, min_LSB, secs_MSB, secs_LSB};
  endfunction

  // Advance n rising edges; inputs are driven and outputs sampled at negedges.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1'b1; cycles(1);
      inc_min = 1'b0; cycles(1);
    end
  endtask

  task automatic pulse_hr(input int n);
    repeat (n) begin
      inc_hr = 1'b1; cycles(1);
      inc_hr = 1'b0; cycles(1);
    end
  endtask

  task automatic pulse_clr();
    clr_sec = 1'b1; cycles(1);
    clr_sec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; inc_min = 1'b0; inc_hr = 1'b0; clr_sec = 1'b0;
    #1;
    checks++;
    if ({disp(), sec_tick, day_tick} !== 26'h0) begin
      $display("FAIL reset_state: got %h/%b%b expected 000000/00", disp(), sec_tick, day_tick);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycles(1);
      checks++;
      if ({disp(), sec_tick} !== 25'h0) begin
        $display("FAIL pre_tick_hold edge %0d: got %h/%b expected 000000/0", i, disp(), sec_tick);
        errors++;
      end
    end
    cycles(1);
    checks++;
    if ({disp(), sec_tick} !== {24'h000001, 1'b1}) begin
      $display("FAIL first_tick: got %h/%b expected 000001/1", disp(), sec_tick);
      errors++;
    end
    cycles(1);
    checks++;
    if (sec_tick !== 1'b0) begin
      $display("FAIL sec_tick_width: got %b expected 0", sec_tick);
      errors++;
    end
  endtask

  task automatic test_count();
    cycles(35);
    checks++;
    if ({disp(), sec_tick} !== {24'h000010, 1'b1}) begin
      $display("FAIL count_40_cycles: got %h/%b expected 000010/1", disp(), sec_tick);
      errors++;
    end
  endtask

  task automatic test_min_carry();
    run = 1'b0;
    pulse_clr();
    checks++;
    if (disp() !== 24'h000000) begin
      $display("FAIL clr_sec_paused: got %h expected 000000", disp());
      errors++;
    end
    run = 1'b1;
    cycles(4 * 59 + 3);
    checks++;
    if ({disp(), sec_tick} !== {24'h000059, 1'b0}) begin
      $display("FAIL reach_59: got %h/%b expected 000059/0", disp(), sec_tick);
      errors++;
    end
    cycles(1);
    checks++;
    if ({disp(), sec_tick, day_tick} !== {24'h000100, 2'b10}) begin
      $display("FAIL min_carry: got %h/%b%b expected 000100/10", disp(), sec_tick, day_tick);
      errors++;
    end
  endtask

  task automatic test_day_wrap();
    run = 1'b0;
    do_reset();
    pulse_hr(23);
    pulse_min(59);
    checks++;
    if (disp() !== 24'h235900) begin
      $display("FAIL set_2359: got %h expected 235900", disp());
      errors++;
    end
    run = 1'b1;
    cycles(4 * 59);
    checks++;
    if ({disp(), day_tick} !== {24'h235959, 1'b0}) begin
      $display("FAIL reach_235959: got %h/%b expected 235959/0", disp(), day_tick);
      errors++;
    end
    cycles(4);
    checks++;
    if ({disp(), sec_tick, day_tick} !== {24'h000000, 2'b11}) begin
      $display("FAIL day_wrap: got %h/%b%b expected 000000/11", disp(), sec_tick, day_tick);
      errors++;
    end
    cycles(1);
    checks++;
    if (day_tick !== 1'b0) begin
      $display("FAIL day_tick_width: got %b expected 0", day_tick);
      errors++;
    end
  endtask

  task automatic test_set_mode();
    run = 1'b0;
    pulse_hr(1);
    pulse_min(59);
    checks++;
    if (disp() !== 24'h015900) begin
      $display("FAIL set_0159: got %h expected 015900", disp());
      errors++;
    end
    pulse_min(1);
    checks++;
    if (disp() !== 24'h010000) begin
      $display("FAIL set_min_no_carry: got %h expected 010000", disp());
      errors++;
    end
    inc_hr = 1'b1; cycles(10); inc_hr = 1'b0; cycles(1);
    checks++;
    if (disp() !== 24'h020000) begin
      $display("FAIL held_inc_hr: got %h expected 020000", disp());
      errors++;
    end
    inc_hr = 1'b1; inc_min = 1'b1; cycles(1);
    inc_hr = 1'b0; inc_min = 1'b0; cycles(1);
    checks++;
    if (disp() !== 24'h030100) begin
      $display("FAIL both_set_edges: got %h expected 030100", disp());
      errors++;
    end
    pulse_hr(20);
    checks++;
    if ({disp(), day_tick} !== {24'h230100, 1'b0}) begin
      $display("FAIL set_hr_23: got %h/%b expected 230100/0", disp(), day_tick);
      errors++;
    end
    inc_hr = 1'b1; cycles(1); inc_hr = 1'b0;
    checks++;
    if ({disp(), day_tick} !== {24'h000100, 1'b0}) begin
      $display("FAIL set_hr_wrap: got %h/%b expected 000100/0", disp(), day_tick);
      errors++;
    end
    cycles(1);
  endtask

  task automatic test_pause();
    pulse_clr();
    run = 1'b1; cycles(2);
    run = 1'b0; cycles(10);
    run = 1'b1; cycles(1);
    checks++;
    if ({disp(), sec_tick} !== {24'h000100, 1'b0}) begin
      $display("FAIL pause_hold: got %h/%b expected 000100/0", disp(), sec_tick);
      errors++;
    end
    cycles(1);
    checks++;
    if ({disp(), sec_tick} !== {24'h000101, 1'b1}) begin
      $display("FAIL pause_resume: got %h/%b expected 000101/1", disp(), sec_tick);
      errors++;
    end
  endtask

  task automatic test_run_ignore_and_clr();
    inc_min = 1'b1; cycles(1);
    run = 1'b0; cycles(3);
    checks++;
    if (disp() !== 24'h000101) begin
      $display("FAIL inc_min_while_run: got %h expected 000101", disp());
      errors++;
    end
    inc_min = 1'b0;
    pulse_clr();
    run = 1'b1;
    cycles(4 * 59 + 3);
    checks++;
    if (disp() !== 24'h000159) begin
      $display("FAIL reach_0159: got %h expected 000159", disp());
      errors++;
    end
    clr_sec = 1'b1; cycles(1); clr_sec = 1'b0;
    checks++;
    if ({disp(), sec_tick} !== {24'h000100, 1'b0}) begin
      $display("FAIL clr_beats_tick: got %h/%b expected 000100/0", disp(), sec_tick);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    run = 1'b0;
    do_reset();
    pulse_hr(12);
    pulse_min(34);
    run = 1'b1;
    cycles(4 * 56);
    checks++;
    if (disp() !== 24'h123456) begin
      $display("FAIL reach_123456: got %h expected 123456", disp());
      errors++;
    end
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({disp(), sec_tick, day_tick} !== 26'h0) begin
      $display("FAIL async_reset: got %h/%b%b expected 000000/00", disp(), sec_tick, day_tick);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    checks++;
    if ({disp(), sec_tick} !== 25'h0) begin
      $display("FAIL post_reset_hold: got %h/%b expected 000000/0", disp(), sec_tick);
      errors++;
    end
    cycles(1);
    checks++;
    if ({disp(), sec_tick} !== {24'h000001, 1'b1}) begin
      $display("FAIL post_reset_tick: got %h/%b expected 000001/1", disp(), sec_tick);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_min_carry();
    test_day_wrap();
    test_set_mode();
    test_pause();
    test_run_ignore_and_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
